mem_arbiter: RTL and testbench

Two-port arbiter and sequencer that shares the single-ported main memory between the core's instruction-fetch port and load/store data port. It accepts level-held requests, grants one per transaction with round-robin fairness, drives the memory's read/write/address/data lines, waits for the memory's `ready`, and returns read data with a one-cycle acknowledge. A watchdog flags a memory that never answers. The block sits between the pipeline's fetch/MEM stages and main memory.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arbiter_rr_pick2.sv | 20 ++
 rtl/mem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory arbiter.
// Imported by the arbiter, its picker and benches.
package mem_arb_pkg;

  localparam int ADDR_W_DEF  = 12;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_t;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin picker.
// Bit 0 / bit 1 are the two requesters; last names the previous winner.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  // Lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    grant = 2'b00;
    unique case (1'b1)
      (req == 2'b11): grant = last ? 2'b01 : 2'b10;
      (req == 2'b01): grant = 2'b01;
      (req == 2'b10): grant = 2'b10;
      default:        grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter and sequencer for single-ported main memory.
// Registered outputs, round-robin grant, watchdog abort.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              err,
  output logic              busy,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_read,
  output logic              m_write,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  state_t            state, state_n;
  port_t             owner, owner_n;
  port_t             last_grant, last_n;
  logic              we, we_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [1:0]        grant;

  logic              i_ack_n, d_ack_n, err_n, busy_n;
  logic              m_read_n, m_write_n;
  logic [ADDR_W-1:0] m_addr_n;
  logic [DATA_W-1:0] m_wdata_n;
  logic [DATA_W-1:0] i_rdata_n, d_rdata_n;

  rr_pick2 u_pick (
    .req   ({d_req, i_req}),
    .last  (last_grant),
    .grant (grant)
  );

  // Next state plus next value of every registered output.
  always_comb begin
    state_n   = state;
    owner_n   = owner;
    last_n    = last_grant;
    we_n      = we;
    cnt_n     = cnt;
    m_addr_n  = m_addr;
    m_wdata_n = m_wdata;
    i_rdata_n = i_rdata;
    d_rdata_n = d_rdata;
    m_read_n  = 1'b0;
    m_write_n = 1'b0;
    i_ack_n   = 1'b0;
    d_ack_n   = 1'b0;
    err_n     = 1'b0;
    unique case (state)
      IDLE: begin
        if (|grant) begin
          state_n = ISSUE;
          cnt_n   = '0;
          if (grant[1]) begin
            owner_n   = PORT_D;
            we_n      = d_we;
            m_addr_n  = d_addr;
            m_wdata_n = d_wdata;
          end else begin
            owner_n   = PORT_I;
            we_n      = 1'b0;
            m_addr_n  = i_addr;
          end
          m_read_n  = ~we_n;
          m_write_n = we_n;
        end
      end
      ISSUE: begin
        if (m_ready) begin
          state_n = RESP;
          if (owner == PORT_D) begin
            d_ack_n = 1'b1;
            if (!we) d_rdata_n = m_rdata;
          end else begin
            i_ack_n   = 1'b1;
            i_rdata_n = m_rdata;
          end
        end else if (cnt == CNT_MAX) begin
          // Memory never answered: abort with zero read data.
          state_n = RESP;
          err_n   = 1'b1;
          if (owner == PORT_D) begin
            d_ack_n = 1'b1;
            if (!we) d_rdata_n = '0;
          end else begin
            i_ack_n   = 1'b1;
            i_rdata_n = '0;
          end
        end else begin
          cnt_n     = cnt + 1'b1;
          m_read_n  = ~we;
          m_write_n = we;
        end
      end
      RESP: begin
        last_n  = owner;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  // State and output registers; reset drops strobes and acks at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= PORT_I;
      last_grant <= PORT_I;
      we         <= 1'b0;
      cnt        <= '0;
      m_addr     <= '0;
      m_wdata    <= '0;
      m_read     <= 1'b0;
      m_write    <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      owner      <= owner_n;
      last_grant <= last_n;
      we         <= we_n;
      cnt        <= cnt_n;
      m_addr     <= m_addr_n;
      m_wdata    <= m_wdata_n;
      m_read     <= m_read_n;
      m_write    <= m_write_n;
      i_rdata    <= i_rdata_n;
      d_rdata    <= d_rdata_n;
      i_ack      <= i_ack_n;
      d_ack      <= d_ack_n;
      err        <= err_n;
      busy       <= busy_n;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a one-cycle memory model.
// Inputs driven 1ns after posedge, outputs sampled at negedge.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req, d_we;
  logic [11:0] i_addr, d_addr;
  logic [31:0] d_wdata;
  logic        i_ack, d_ack, err, busy;
  logic [31:0] i_rdata, d_rdata;
  logic [11:0] m_addr;
  logic [31:0] m_wdata, m_rdata;
  logic        m_read, m_write;
  logic        m_ready = 1'b0;

  logic        stall;
  logic        ld_en;
  logic [11:0] ld_addr;
  logic [31:0] ld_data;
  logic [31:0] mem [0:4095];
  logic        saw_write = 1'b0;

  int errors = 0;
  int checks = 0;

  mem_arbiter dut (
    .clk     (clk),
    .reset   (rst_n),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_ack   (i_ack),
    .i_rdata (i_rdata),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_ack   (d_ack),
    .d_rdata (d_rdata),
    .err     (err),
    .busy    (busy),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_read  (m_read),
    .m_write (m_write),
    .m_rdata (m_rdata),
    .m_ready (m_ready)
  );

  always #5 clk = ~clk;

  // Memory: answers the cycle after a strobe is sampled.
  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (m_write) mem[m_addr] <= m_wdata;
    m_rdata <= mem[m_addr];
    m_ready <= (m_read | m_write) & ~stall;
  end

  always @(negedge clk)
    if (m_write && m_addr == 12'h3FF && m_wdata == 32'hA5A5A5A5)
      saw_write = 1'b1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [11:0] a, input logic [31:0] v);
    @(posedge clk); #1;
    ld_en = 1'b1; ld_addr = a; ld_data = v;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  // One request; lat = negedge index of ack, -1 if none.
  task automatic txn(input bit is_d, input bit we,
                     input logic [11:0] a, input logic [31:0] wd,
                     output int lat, output logic e);
    lat = -1;
    e   = 1'b0;
    @(posedge clk); #1;
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
    end else begin
      i_req = 1'b1; i_addr = a;
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (is_d ? d_ack : i_ack) begin
        lat = c;
        e   = err;
        break;
      end
    end
    @(posedge clk); #1;
    i_req = 1'b0;
    d_req = 1'b0;
  endtask

  int   lat;
  logic e;
  int   n_acks;
  int   both;
  int   ack_cyc [4];
  bit   ack_d   [4];
  int   n_extra;

  initial begin
    rst_n = 1'b0;
    i_req = 0; d_req = 0; d_we = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    stall = 0; ld_en = 0; ld_addr = '0; ld_data = '0;

    repeat (2) @(negedge clk);
    check("rst i_ack", i_ack, 0);
    check("rst d_ack", d_ack, 0);
    check("rst err", err, 0);
    check("rst busy", busy, 0);
    check("rst m_read", m_read, 0);
    check("rst m_write", m_write, 0);
    check("rst m_addr", m_addr, 0);
    check("rst m_wdata", m_wdata, 0);
    check("rst i_rdata", i_rdata, 0);
    check("rst d_rdata", d_rdata, 0);
    @(negedge clk) rst_n = 1'b1;

    preload(12'h010, 32'hDEADBEEF);
    preload(12'h020, 32'h11111111);
    preload(12'h030, 32'h22222222);

    // Single load, cycle by cycle.
    @(posedge clk); #1;
    d_req = 1; d_we = 0; d_addr = 12'h010;
    @(negedge clk);
    check("ld c0 busy", busy, 0);
    check("ld c0 m_read", m_read, 0);
    @(negedge clk);
    check("ld c1 m_read", m_read, 1);
    check("ld c1 m_addr", m_addr, 12'h010);
    check("ld c1 busy", busy, 1);
    @(negedge clk);
    check("ld c2 m_read", m_read, 1);
    check("ld c2 d_ack", d_ack, 0);
    @(negedge clk);
    check("ld c3 d_ack", d_ack, 1);
    check("ld c3 d_rdata", d_rdata, 32'hDEADBEEF);
    check("ld c3 m_read", m_read, 0);
    check("ld c3 err", err, 0);
    @(posedge clk); #1;
    d_req = 0;
    @(negedge clk);
    check("ld c4 d_ack", d_ack, 0);
    check("ld c4 busy", busy, 0);

    // Store then fetch of the same word.
    txn(1, 1, 12'h3FF, 32'hA5A5A5A5, lat, e);
    check("st lat", lat, 3);
    check("st strobe", saw_write, 1);
    check("st d_rdata kept", d_rdata, 32'hDEADBEEF);
    txn(0, 0, 12'h3FF, 32'h0, lat, e);
    check("if lat", lat, 3);
    check("if i_rdata", i_rdata, 32'hA5A5A5A5);

    // Both ports held from reset: D, I, D, I every 4 cycles.
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    i_req = 1; i_addr = 12'h020;
    d_req = 1; d_we = 0; d_addr = 12'h030;
    n_acks = 0;
    both = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (i_ack && d_ack) both++;
      if ((i_ack || d_ack) && n_acks < 4) begin
        ack_cyc[n_acks] = c;
        ack_d[n_acks]   = d_ack;
        n_acks++;
      end
    end
    @(posedge clk); #1;
    i_req = 0;
    d_req = 0;
    check("rr n_acks", n_acks, 4);
    check("rr double", both, 0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rr cyc%0d", k), ack_cyc[k], 3 + 4 * k);
      check($sformatf("rr port%0d", k), ack_d[k], (k % 2 == 0));
    end
    check("rr i_rdata", i_rdata, 32'h11111111);
    check("rr d_rdata", d_rdata, 32'h22222222);
    repeat (6) @(negedge clk);
    check("rr idle", busy, 0);

    // Stalled memory: abort after TIMEOUT issue cycles.
    stall = 1;
    txn(1, 0, 12'h010, 32'h0, lat, e);
    check("to lat", lat, 16);
    check("to err", e, 1);
    check("to d_rdata", d_rdata, 0);
    @(negedge clk);
    check("to busy", busy, 0);
    check("to err drop", err, 0);
    stall = 0;

    // Reset during ISSUE, then tie must go to data.
    @(posedge clk); #1;
    d_req = 1; d_we = 0; d_addr = 12'h010;
    repeat (2) @(negedge clk);
    check("ri c1 m_read", m_read, 1);
    #2 rst_n = 1'b0;
    #1;
    check("ri m_read", m_read, 0);
    check("ri m_write", m_write, 0);
    check("ri busy", busy, 0);
    check("ri d_ack", d_ack, 0);
    d_req = 0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    i_req = 1; i_addr = 12'h020;
    d_req = 1; d_we = 0; d_addr = 12'h030;
    lat = -1;
    e   = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (i_ack || d_ack) begin
        lat = c;
        e   = d_ack;
        break;
      end
    end
    @(posedge clk); #1;
    i_req = 0;
    d_req = 0;
    check("ri tie lat", lat, 3);
    check("ri tie port", e, 1);
    check("ri tie data", d_rdata, 32'h22222222);

    // One ack per request dropped at the edge after ack.
    repeat (3) @(negedge clk);
    txn(0, 0, 12'h020, 32'h0, lat, e);
    check("pc lat", lat, 3);
    n_extra = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (i_ack || d_ack) n_extra++;
    end
    check("pc extra acks", n_extra, 0);
    check("pc busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
